// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions and the NOP encoding.
package cpu_pkg;

   localparam int OP_HI     = 31;
   localparam int OP_LO     = 26;
   localparam int RS_HI     = 25;
   localparam int RS_LO     = 21;
   localparam int RT_HI     = 20;
   localparam int RT_LO     = 16;
   localparam int RD_HI     = 15;
   localparam int RD_LO     = 11;
   localparam int SA_HI     = 10;
   localparam int SA_LO     = 6;
   localparam int FUNCT_HI  = 5;
   localparam int FUNCT_LO  = 0;
   localparam int IMM_HI    = 15;
   localparam int IMM_LO    = 0;
   localparam int TARGET_HI = 25;
   localparam int TARGET_LO = 0;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/ir_fifo.sv
// Generic synchronous FIFO with push, pop, synchronous clear, occupancy count and head data.
module ir_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32,
   localparam int unsigned PW = $clog2(DEPTH),
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push_en, pop_en;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   assign count   = cnt_q;
   assign rdata   = mem[rd_ptr_q];

   always_comb begin
      cnt_d = cnt_q;
      unique case ({push_en, pop_en})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointers are log2(DEPTH) wide so they wrap without explicit compare.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_en) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_en)  rd_ptr_q <= rd_ptr_q + PW'(1);
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push_en && !clear) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/ir_queue.sv
// Instruction register fed by a prefetch queue, with optional empty-queue bypass,
// flush to NOP and combinational field decode of the current IR.
module ir_queue
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter logic [31:0] RESET_INSTR = NOP_INSTR,
   parameter bit          BYPASS      = 1'b1,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   instructionIn,
   input  logic          IRWre,
   input  logic          flush,
   output logic [31:0]   instructionOut,
   output logic          ir_valid,
   output logic [CW-1:0] count,
   output logic [5:0]    op,
   output logic [4:0]    rs,
   output logic [4:0]    rt,
   output logic [4:0]    rd,
   output logic [4:0]    sa,
   output logic [5:0]    funct,
   output logic [15:0]   imm16,
   output logic [25:0]   target
);

   logic [31:0] ir_q, ir_d;
   logic        irv_q, irv_d;
   logic [31:0] head;
   logic        full, empty;
   logic        fifo_push, fifo_pop, bypass_take;

   ir_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .CLK   (CLK),
      .RST_N (RST_N),
      .clear (flush),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (instructionIn),
      .rdata (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Ready ignores IRWre so a full queue never accepts a word, even while popping.
   assign in_ready  = !flush && !full;
   assign fifo_push = in_valid && in_ready && !bypass_take;

   always_comb begin
      ir_d        = ir_q;
      irv_d       = irv_q;
      fifo_pop    = 1'b0;
      bypass_take = 1'b0;
      if (flush) begin
         ir_d  = RESET_INSTR;
         irv_d = 1'b0;
      end else if (IRWre) begin
         if (!empty) begin
            ir_d     = head;
            irv_d    = 1'b1;
            fifo_pop = 1'b1;
         end else if (BYPASS && in_valid) begin
            ir_d        = instructionIn;
            irv_d       = 1'b1;
            bypass_take = 1'b1;
         end else begin
            irv_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ir_q  <= RESET_INSTR;
         irv_q <= 1'b0;
      end else begin
         ir_q  <= ir_d;
         irv_q <= irv_d;
      end
   end

   assign instructionOut = ir_q;
   assign ir_valid       = irv_q;

   assign op     = ir_q[OP_HI:OP_LO];
   assign rs     = ir_q[RS_HI:RS_LO];
   assign rt     = ir_q[RT_HI:RT_LO];
   assign rd     = ir_q[RD_HI:RD_LO];
   assign sa     = ir_q[SA_HI:SA_LO];
   assign funct  = ir_q[FUNCT_HI:FUNCT_LO];
   assign imm16  = ir_q[IMM_HI:IMM_LO];
   assign target = ir_q[TARGET_HI:TARGET_LO];

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised successor to the multicycle CPU's single instruction register. It adds a DEPTH-entry prefetch queue between instruction memory and the IR, an optional same-cycle bypass, a pipeline flush, and registered-IR field decode. It sits between the instruction memory read port and the control unit and datapath register-file addressing, so instruction fetch can run ahead of execute.

## Interface
Parameters:
- DEPTH, 4: queue entries; a power of two, at least 2.
- RESET_INSTR, 32'h0000_0000: value loaded into the IR at reset and on flush (NOP).
- BYPASS, 1: 1 lets an empty queue forward instructionIn straight into the IR.

Ports:
- Clock and reset: one clock `CLK`; reset `RST_N` is asynchronous and active-low.
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- in_valid  in  1  instructionIn holds a fetched word.
- in_ready  out  1  queue accepts a word this cycle.
- instructionIn  in  32  fetched instruction word.
- IRWre  in  1  advance: load the next instruction into the IR.
- flush  in  1  discard queued and current instructions (branch or jump taken).
- instructionOut  out  32  current IR contents.
- ir_valid  out  1  instructionOut holds a real instruction, not a bubble.
- count  out  $clog2(DEPTH+1)  number of queued words, excluding the IR.
- op  out  6  instructionOut[31:26].
- rs  out  5  instructionOut[25:21].
- rt  out  5  instructionOut[20:16].
- rd  out  5  instructionOut[15:11].
- sa  out  5  instructionOut[10:6].
- funct  out  6  instructionOut[5:0].
- imm16  out  16  instructionOut[15:0].
- target  out  26  instructionOut[25:0].

## Operation
- **Reset (RST_N low):** count=0, read and write pointers=0, instructionOut=RESET_INSTR, ir_valid=0. Release is synchronous to CLK.
- **in_ready:** equals `!flush && count<DEPTH`. Combinational; it does not depend on IRWre, so a full queue never accepts a word, even when it pops in the same cycle.
- **Push:** occurs when `in_valid && in_ready`. The word is written at the write pointer, which then increments modulo DEPTH.
- **Advance (IRWre=1, flush=0), by case:**
  - Queue non-empty: IR takes the head entry, the queue pops, ir_valid=1. A push in the same cycle is also taken, so count is unchanged.
  - Queue empty, BYPASS=1, in_valid=1: IR takes instructionIn, ir_valid=1. The word is consumed and not enqueued, so count stays 0.
  - Queue empty otherwise: IR holds its old value, ir_valid=0 (bubble).
- **Hold (IRWre=0):** IR and ir_valid hold; pushes continue.
- **Flush:** has priority over advance and push. On the edge: count=0, pointers=0, IR=RESET_INSTR, ir_valid=0. A word presented during the flush cycle is dropped.
- **Decode outputs:** purely combinational slices of instructionOut; they are valid whenever ir_valid=1.
- **Pointer wrap:** pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from count, never from pointer equality.

## Timing
- A word pushed at edge N can enter the IR at edge N+1 at the earliest, when IRWre=1 in that cycle.
- Bypass latency: the word presented in cycle N is in the IR after edge N.
- in_ready reflects count after the previous edge and has no combinational path from IRWre.
- Assertion of RST_N takes effect on outputs immediately, independent of CLK. A reset in the middle of a fill discards all queued words.
- Throughput: one instruction per cycle sustained when in_valid=1 and IRWre=1.

## Structure
- Shared package `cpu_pkg`:
  - field-position constants: OP_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO, SA_HI/LO, FUNCT_HI/LO, IMM_HI/LO, TARGET_HI/LO;
  - NOP_INSTR, used as the default for RESET_INSTR.
- One sub-module, `ir_fifo`: a generic synchronous FIFO with push, pop, clear, count, and head data.
- ir_queue itself contains only the IR register, the bypass/advance/flush priority logic, and the decode slices.

## Test plan
- **Reset:** drive RST_N low mid-cycle. Expect instructionOut=0, ir_valid=0, count=0, and in_ready=1 immediately.
- **Fill to full:** DEPTH=4, IRWre=0, push 0x20010001..0x20010004. Expect count=4 and in_ready=0. A fifth word stays presented and is not accepted.
- **Drain:** from the full state, hold IRWre=1 for 5 cycles. Expect instructionOut to step 0x20010001..0x20010004 in order with ir_valid=1; on the 5th cycle ir_valid=0 and IR holds 0x20010004.
- **Bypass:** empty queue, BYPASS=1, present 0x8C220008 with IRWre=1. Expect instructionOut=0x8C220008 after one edge, count=0, op=0x23, rs=1, rt=2, imm16=0x0008. With BYPASS=0 the same stimulus gives ir_valid=0 and count=1.
- **Flush vs push:** with count=3, assert flush, IRWre, and in_valid together. Expect count=0, IR=RESET_INSTR, ir_valid=0, and the input word dropped.
- **Wrap-around:** run 3×DEPTH interleaved pushes and pops with random stalls. Expect the output order to match the input order.
